// File: rtl/serial_cmp_ctrl.sv
// Multi-cycle unsigned magnitude comparator: one shared 4-bit compare slice
// walks the latched operands MSB nibble first and exits on the first difference.
module cp_4bit (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   output logic       lt_o,
   output logic       eq_o,
   output logic       gt_o
);
   assign lt_o = (a_i < b_i);
   assign eq_o = (a_i == b_i);
   assign gt_o = (a_i > b_i);
endmodule

module serial_cmp_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] A,
   input  logic [4*NIBBLES-1:0] B,
   output logic                 busy,
   output logic                 done,
   output logic                 A_lt_B,
   output logic                 A_eq_B,
   output logic                 A_gt_B,
   output logic [2:0]           nib_cnt
);
   localparam int         W        = 4 * NIBBLES;
   localparam logic [2:0] LAST_IDX = 3'(NIBBLES - 1);
   localparam logic [2:0] NIB_FULL = 3'(NIBBLES);

   typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d;
   logic [2:0]     idx_q, idx_d, cnt_q, cnt_d;
   logic           lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
   logic [2:0]     nib_cnt_q, nib_cnt_d;
   logic [3:0]     nib_a, nib_b;
   logic           slice_lt, slice_eq, slice_gt;

   assign nib_a = a_q[idx_q*4 +: 4];
   assign nib_b = b_q[idx_q*4 +: 4];

   cp_4bit u_cp (
      .a_i  (nib_a),
      .b_i  (nib_b),
      .lt_o (slice_lt),
      .eq_o (slice_eq),
      .gt_o (slice_gt)
   );

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      lt_d      = lt_q;
      eq_d      = eq_q;
      gt_d      = gt_q;
      nib_cnt_d = nib_cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               idx_d   = LAST_IDX;
               cnt_d   = 3'd0;
               state_d = CMP;
            end
         end
         CMP: begin
            // First differing nibble decides; the rest are never examined.
            if (!slice_eq) begin
               lt_d      = slice_lt;
               eq_d      = 1'b0;
               gt_d      = slice_gt;
               nib_cnt_d = cnt_q + 3'd1;
               state_d   = DONE;
            end else if (idx_q == 3'd0) begin
               lt_d      = 1'b0;
               eq_d      = 1'b1;
               gt_d      = 1'b0;
               nib_cnt_d = NIB_FULL;
               state_d   = DONE;
            end else begin
               idx_d = idx_q - 3'd1;
               cnt_d = cnt_q + 3'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         idx_q     <= 3'd0;
         cnt_q     <= 3'd0;
         lt_q      <= 1'b0;
         eq_q      <= 1'b0;
         gt_q      <= 1'b0;
         nib_cnt_q <= 3'd0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         lt_q      <= lt_d;
         eq_q      <= eq_d;
         gt_q      <= gt_d;
         nib_cnt_q <= nib_cnt_d;
      end
   end

   assign busy    = (state_q == CMP);
   assign done    = (state_q == DONE);
   assign A_lt_B  = lt_q;
   assign A_eq_B  = eq_q;
   assign A_gt_B  = gt_q;
   assign nib_cnt = nib_cnt_q;
endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Directed and random checks of serial_cmp_ctrl against a bench-side
// unsigned compare model; inputs driven on negedge, outputs sampled on negedge.
module tb_serial_cmp_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] A = '0;
   logic [15:0] B = '0;
   logic        busy, done, A_lt_B, A_eq_B, A_gt_B;
   logic [2:0]  nib_cnt;

   int checks = 0;
   int failures = 0;

   serial_cmp_ctrl #(.NIBBLES(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .A       (A),
      .B       (B),
      .busy    (busy),
      .done    (done),
      .A_lt_B  (A_lt_B),
      .A_eq_B  (A_eq_B),
      .A_gt_B  (A_gt_B),
      .nib_cnt (nib_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Expected nibbles examined: position of first differing nibble from the MSB.
   function automatic int exp_nibs(input logic [15:0] a, input logic [15:0] b);
      for (int i = 3; i >= 0; i--)
         if (a[i*4 +: 4] != b[i*4 +: 4]) return 4 - i;
      return 4;
   endfunction

   // mode 0: plain; 1: A forced to 0 during CMP; 2: start re-pulsed with A=1 during CMP
   task automatic run_cmp(input logic [15:0] a, input logic [15:0] b, input int mode);
      int k;
      int ek;
      ek = exp_nibs(a, b);
      @(negedge clk);
      A = a; B = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_in_cmp", {31'd0, busy}, 32'd1);
      if (mode == 1) A = 16'h0000;
      if (mode == 2) begin A = 16'h0001; start = 1'b1; end
      k = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         k++;
      end while (!done && k < 12);
      chk("latency", k, ek);
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      chk("lt", {31'd0, A_lt_B}, {31'd0, (a < b)});
      chk("eq", {31'd0, A_eq_B}, {31'd0, (a == b)});
      chk("gt", {31'd0, A_gt_B}, {31'd0, (a > b)});
      chk("nib_cnt", {29'd0, nib_cnt}, ek);
      $display("cmp A=%h B=%h mode=%0d lt=%0b eq=%0b gt=%0b nib=%0d edges=%0d",
               a, b, mode, A_lt_B, A_eq_B, A_gt_B, nib_cnt, k);
      @(negedge clk);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
   endtask

   initial begin
      logic [15:0] ra, rb;
      // Reset, with start asserted at the same time to test priority.
      start = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_res", {29'd0, A_lt_B, A_eq_B, A_gt_B}, 32'd0);
      chk("rst_nib", {29'd0, nib_cnt}, 32'd0);
      start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      run_cmp(16'h9000, 16'h1FFF, 0);
      run_cmp(16'h1234, 16'h1235, 0);
      run_cmp(16'hABCD, 16'hABCD, 1);

      // Start ignored during CMP, not queued.
      run_cmp(16'h0F00, 16'h0E00, 2);
      repeat (4) begin
         @(negedge clk);
         chk("no_requeue_busy", {31'd0, busy}, 32'd0);
         chk("no_requeue_done", {31'd0, done}, 32'd0);
      end
      chk("held_gt", {31'd0, A_gt_B}, 32'd1);
      chk("held_nib", {29'd0, nib_cnt}, 32'd2);

      // Abort during second CMP cycle.
      A = 16'h5555; B = 16'h5555; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("abort_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_res", {29'd0, A_lt_B, A_eq_B, A_gt_B}, 32'd0);
      chk("abort_nib", {29'd0, nib_cnt}, 32'd0);
      repeat (6) begin
         @(negedge clk);
         chk("abort_no_done", {31'd0, done}, 32'd0);
      end
      chk("abort_persist", {26'd0, A_lt_B, A_eq_B, A_gt_B, nib_cnt}, 32'd0);

      // Boundary values, then random back-to-back compares.
      run_cmp(16'h0000, 16'h0000, 0);
      run_cmp(16'hFFFF, 16'h0000, 0);
      run_cmp(16'hFFFE, 16'hFFFF, 0);
      for (int n = 0; n < 100; n++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         case (n % 4)
            1: rb = ra;
            2: rb = {ra[15:4], 4'($urandom)};
            3: rb = {ra[15:8], 8'($urandom)};
            default: ;
         endcase
         run_cmp(ra, rb, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
